// File: rtl/regfile_pkg.sv
// Shared constants, read-source encoding and reset-content helper for the
// scoreboarded register file.
package regfile_pkg;

    localparam int REGFILE_N    = 64;
    localparam int REGFILE_REGS = 32;

    // Which source drives a combinational read port this cycle.
    typedef enum logic [1:0] {
        SRC_ZERO  = 2'd0,
        SRC_ARRAY = 2'd1,
        SRC_WP3   = 2'd2,
        SRC_WP4   = 2'd3
    } rd_src_e;

    function automatic logic [63:0] reset_value(input int unsigned idx,
                                                input int unsigned zero_reg);
        return (idx == zero_reg) ? 64'd0 : 64'(idx);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits and the operand-ready lookup for both read
// ports, including the same-cycle bypass term.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int REGS     = REGFILE_REGS,
    parameter int AW       = $clog2(REGS),
    parameter int ZERO_REG = REGS - 1,
    parameter int BYPASS   = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_alloc_en,
    input  logic [AW-1:0] i_alloc_a,
    input  logic          i_wv3,
    input  logic [AW-1:0] i_wa3,
    input  logic          i_wv4,
    input  logic [AW-1:0] i_wa4,
    input  logic [AW-1:0] i_ra1,
    input  logic [AW-1:0] i_ra2,
    output logic          o_rdy1,
    output logic          o_rdy2
);

    localparam logic [AW:0]   REGS_L = (AW + 1)'(REGS);
    localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);

    logic [REGS-1:0] r_pending;
    logic            w_alloc_v;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < REGS_L;
    endfunction

    assign w_alloc_v = i_alloc_en && in_range(i_alloc_a) && (i_alloc_a != ZERO_A);

    // A new producer supersedes any completing write to the same register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= '0;
        end else begin
            for (int i = 0; i < REGS; i++) begin
                if (w_alloc_v && (i_alloc_a == AW'(i)))
                    r_pending[i] <= 1'b1;
                else if ((i_wv3 && (i_wa3 == AW'(i))) || (i_wv4 && (i_wa4 == AW'(i))))
                    r_pending[i] <= 1'b0;
            end
        end
    end

    function automatic logic lookup(input logic [AW-1:0] ra,
                                    input logic [REGS-1:0] pend,
                                    input logic wv3, input logic [AW-1:0] wa3,
                                    input logic wv4, input logic [AW-1:0] wa4);
        logic rdy;
        rdy = 1'b1;
        if (in_range(ra) && (ra != ZERO_A)) begin
            rdy = ~pend[ra];
            if ((BYPASS != 0) && ((wv3 && (wa3 == ra)) || (wv4 && (wa4 == ra))))
                rdy = 1'b1;
        end
        return rdy;
    endfunction

    always_comb begin
        o_rdy1 = lookup(i_ra1, r_pending, i_wv3, i_wa3, i_wv4, i_wa4);
        o_rdy2 = lookup(i_ra2, r_pending, i_wv3, i_wa3, i_wv4, i_wa4);
    end

endmodule

// File: rtl/regfile_sb.sv
// Two-read / two-write register file with a hardwired-zero register, optional
// write-to-read bypass and a pending-write scoreboard for RAW stalls.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int N        = REGFILE_N,
    parameter int REGS     = REGFILE_REGS,
    parameter int AW       = $clog2(REGS),
    parameter int ZERO_REG = REGS - 1,
    parameter int BYPASS   = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [N-1:0]  rd1,
    output logic [N-1:0]  rd2,
    input  logic          we3,
    input  logic [AW-1:0] wa3,
    input  logic [N-1:0]  wd3,
    input  logic          we4,
    input  logic [AW-1:0] wa4,
    input  logic [N-1:0]  wd4,
    input  logic          alloc_en,
    input  logic [AW-1:0] alloc_a,
    output logic          rdy1,
    output logic          rdy2
);

    localparam logic [AW:0]   REGS_L = (AW + 1)'(REGS);
    localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);

    logic [N-1:0] r_regs [REGS];
    logic         w_wv3;
    logic         w_wv4;
    rd_src_e      w_src1;
    rd_src_e      w_src2;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < REGS_L;
    endfunction

    // Gating with reset_n keeps in-flight writes from bypassing during reset.
    assign w_wv3 = reset_n && we3 && in_range(wa3) && (wa3 != ZERO_A);
    assign w_wv4 = reset_n && we4 && in_range(wa4) && (wa4 != ZERO_A);

    // NOTE: the array is reset on purpose: every register has a defined
    // power-on value (its own index), so it cannot map onto a reset-less RAM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REGS; i++)
                r_regs[i] <= N'(reset_value(i, ZERO_REG));
        end else begin
            for (int i = 0; i < REGS; i++) begin
                if (w_wv4 && (wa4 == AW'(i)))
                    r_regs[i] <= wd4;
                else if (w_wv3 && (wa3 == AW'(i)))
                    r_regs[i] <= wd3;
            end
        end
    end

    function automatic rd_src_e read_src(input logic [AW-1:0] ra,
                                         input logic wv3, input logic [AW-1:0] wa3,
                                         input logic wv4, input logic [AW-1:0] wa4);
        rd_src_e src;
        src = SRC_ZERO;
        if (in_range(ra) && (ra != ZERO_A)) begin
            src = SRC_ARRAY;
            if (BYPASS != 0) begin
                if (wv4 && (wa4 == ra))
                    src = SRC_WP4;
                else if (wv3 && (wa3 == ra))
                    src = SRC_WP3;
            end
        end
        return src;
    endfunction

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a latch behind.
    always_comb begin
        rd1    = '0;
        rd2    = '0;
        w_src1 = read_src(ra1, w_wv3, wa3, w_wv4, wa4);
        w_src2 = read_src(ra2, w_wv3, wa3, w_wv4, wa4);
        case (w_src1)
            SRC_ARRAY: rd1 = r_regs[ra1];
            SRC_WP3:   rd1 = wd3;
            SRC_WP4:   rd1 = wd4;
            default:   rd1 = '0;
        endcase
        case (w_src2)
            SRC_ARRAY: rd2 = r_regs[ra2];
            SRC_WP3:   rd2 = wd3;
            SRC_WP4:   rd2 = wd4;
            default:   rd2 = '0;
        endcase
    end

    regfile_scoreboard #(
        .REGS     (REGS),
        .AW       (AW),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_alloc_en (alloc_en),
        .i_alloc_a  (alloc_a),
        .i_wv3      (w_wv3),
        .i_wa3      (wa3),
        .i_wv4      (w_wv4),
        .i_wa4      (wa4),
        .i_ra1      (ra1),
        .i_ra2      (ra2),
        .o_rdy1     (rdy1),
        .o_rdy2     (rdy2)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: one bypassing and one non-bypassing instance share all
// inputs and are compared against an array-based reference model.
module tb_regfile_sb;

    logic        clk;
    logic        reset_n;
    logic [4:0]  ra1, ra2, wa3, wa4, alloc_a;
    logic        we3, we4, alloc_en;
    logic [63:0] wd3, wd4;
    logic [63:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic        rdy1_b, rdy2_b, rdy1_n, rdy2_n;

    int tests = 0;
    int fails = 0;

    logic [63:0] m_regs [32];
    bit          m_pend [32];

    regfile_sb #(.BYPASS(1)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
        .we3(we3), .wa3(wa3), .wd3(wd3), .we4(we4), .wa4(wa4), .wd4(wd4),
        .alloc_en(alloc_en), .alloc_a(alloc_a), .rdy1(rdy1_b), .rdy2(rdy2_b)
    );

    regfile_sb #(.BYPASS(0)) u_dut_n (
        .clk(clk), .reset_n(reset_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
        .we3(we3), .wa3(wa3), .wd3(wd3), .we4(we4), .wa4(wa4), .wd4(wd4),
        .alloc_en(alloc_en), .alloc_a(alloc_a), .rdy1(rdy1_n), .rdy2(rdy2_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = (i == 31) ? 64'd0 : 64'(i);
            m_pend[i] = 1'b0;
        end
    endfunction

    // Value an ideal register file shows on a read port right now.
    function automatic logic [63:0] m_read(input logic [4:0] ra, input bit byp);
        if (ra == 5'd31) return 64'd0;
        if (byp && reset_n) begin
            if (we4 && wa4 == ra) return wd4;
            if (we3 && wa3 == ra) return wd3;
        end
        return m_regs[ra];
    endfunction

    function automatic logic m_rdy(input logic [4:0] ra, input bit byp);
        if (ra == 5'd31) return 1'b1;
        if (byp && reset_n && ((we4 && wa4 == ra) || (we3 && wa3 == ra))) return 1'b1;
        return !m_pend[ra];
    endfunction

    // Apply the effect of one rising edge: port 3 then port 4 (so 4 wins),
    // completions clear, then a new allocation sets.
    function automatic void m_edge();
        if (we3 && wa3 != 5'd31) m_regs[wa3] = wd3;
        if (we4 && wa4 != 5'd31) m_regs[wa4] = wd4;
        if (we3) m_pend[wa3] = 1'b0;
        if (we4) m_pend[wa4] = 1'b0;
        if (alloc_en && alloc_a != 5'd31) m_pend[alloc_a] = 1'b1;
    endfunction

    task automatic check_all(input string tag);
        check({tag, "/rd1_b"},  rd1_b,  m_read(ra1, 1'b1));
        check({tag, "/rd2_b"},  rd2_b,  m_read(ra2, 1'b1));
        check({tag, "/rd1_n"},  rd1_n,  m_read(ra1, 1'b0));
        check({tag, "/rd2_n"},  rd2_n,  m_read(ra2, 1'b0));
        check({tag, "/rdy1_b"}, 64'(rdy1_b), 64'(m_rdy(ra1, 1'b1)));
        check({tag, "/rdy2_b"}, 64'(rdy2_b), 64'(m_rdy(ra2, 1'b1)));
        check({tag, "/rdy1_n"}, 64'(rdy1_n), 64'(m_rdy(ra1, 1'b0)));
        check({tag, "/rdy2_n"}, 64'(rdy2_n), 64'(m_rdy(ra2, 1'b0)));
    endtask

    task automatic tick();
        m_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        we3 = 1'b0; we4 = 1'b0; alloc_en = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        ra1 = '0; ra2 = '0; wa3 = '0; wa4 = '0; alloc_a = '0;
        we3 = 1'b0; we4 = 1'b0; alloc_en = 1'b0; wd3 = '0; wd4 = '0;
        m_reset();
        #2;
        check_all("reset_hold");
        @(negedge clk);
        reset_n = 1'b1;

        // Reset contents sweep: reg i reads back i, the zero register reads 0.
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(i);
            #1;
            check("sweep_rd1", rd1_b, (i == 31) ? 64'd0 : 64'(i));
            check("sweep_rd2", rd2_n, (i == 31) ? 64'd0 : 64'(i));
            check("sweep_rdy", 64'({rdy1_b, rdy2_b, rdy1_n, rdy2_n}), 64'hF);
        end

        // Bypass versus pre-edge visibility.
        @(negedge clk);
        we3 = 1'b1; wa3 = 5'd5; wd3 = 64'hDEAD_BEEF; ra1 = 5'd5; ra2 = 5'd6;
        #1;
        check("byp_pre_b", rd1_b, 64'hDEAD_BEEF);
        check("byp_pre_n", rd1_n, 64'd5);
        check_all("byp_pre");
        tick();
        idle();
        #1;
        check("byp_post_b", rd1_b, 64'hDEAD_BEEF);
        check("byp_post_n", rd1_n, 64'hDEAD_BEEF);

        // Same-address dual write: port 4 wins. Zero register ignores writes.
        we3 = 1'b1; wa3 = 5'd7; wd3 = 64'd1; we4 = 1'b1; wa4 = 5'd7; wd4 = 64'd2;
        ra1 = 5'd7; ra2 = 5'd31;
        #1;
        check_all("dual_pre");
        tick();
        idle();
        #1;
        check("dual_post", rd1_n, 64'd2);
        we3 = 1'b1; wa3 = 5'd31; wd3 = 64'd9;
        #1;
        check("zero_byp", rd2_b, 64'd0);
        tick();
        idle();
        #1;
        check("zero_post", rd2_n, 64'd0);
        check_all("zero_post");

        // Scoreboard set, alloc-beats-write, clear, and zero-register alloc.
        alloc_en = 1'b1; alloc_a = 5'd3; ra1 = 5'd3;
        tick();
        idle();
        #1;
        check("sb_alloc_b", 64'(rdy1_b), 64'd0);
        check("sb_alloc_n", 64'(rdy1_n), 64'd0);
        alloc_en = 1'b1; alloc_a = 5'd3; we4 = 1'b1; wa4 = 5'd3; wd4 = 64'h33;
        tick();
        idle();
        #1;
        check("sb_alloc_wins", 64'(rdy1_b), 64'd0);
        check_all("sb_alloc_wins");
        we3 = 1'b1; wa3 = 5'd3; wd3 = 64'h44;
        #1;
        check("sb_clear_byp_b", 64'(rdy1_b), 64'd1);
        check("sb_clear_byp_n", 64'(rdy1_n), 64'd0);
        tick();
        idle();
        #1;
        check("sb_clear", 64'(rdy1_n), 64'd1);
        alloc_en = 1'b1; alloc_a = 5'd31; ra1 = 5'd31;
        tick();
        idle();
        #1;
        check("sb_zero_alloc", 64'(rdy1_b & rdy1_n), 64'd1);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            we3 = 1'($urandom_range(0, 1));
            we4 = 1'($urandom_range(0, 1));
            alloc_en = ($urandom_range(0, 2) == 0);
            wa3 = 5'($urandom_range(0, 31));
            wa4 = ($urandom_range(0, 3) == 0) ? wa3 : 5'($urandom_range(0, 31));
            alloc_a = ($urandom_range(0, 3) == 0) ? wa4 : 5'($urandom_range(0, 31));
            wd3 = {$urandom, $urandom};
            wd4 = {$urandom, $urandom};
            ra1 = ($urandom_range(0, 2) == 0) ? wa3 : 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 2) == 0) ? wa4 : 5'($urandom_range(0, 31));
            #1;
            check_all("rand");
            tick();
        end
        idle();

        // Async reset between edges, with a write and alloc in flight.
        we3 = 1'b1; wa3 = 5'd4; wd3 = 64'd99;
        tick();
        idle();
        alloc_en = 1'b1; alloc_a = 5'd4;
        tick();
        idle();
        ra1 = 5'd4; ra2 = 5'd4;
        #1;
        check("pre_rst_rd", rd1_b, 64'd99);
        check("pre_rst_rdy", 64'(rdy1_b), 64'd0);
        we3 = 1'b1; wa3 = 5'd4; wd3 = 64'd123; alloc_en = 1'b1; alloc_a = 5'd4;
        reset_n = 1'b0;
        m_reset();
        #1;
        check("rst_rd_b", rd1_b, 64'd4);
        check("rst_rd_n", rd2_n, 64'd4);
        check("rst_rdy", 64'({rdy1_b, rdy2_n}), 64'd3);
        check_all("rst_async");
        idle();
        #1;
        reset_n = 1'b1;
        #1;
        check_all("rst_release");
        we4 = 1'b1; wa4 = 5'd4; wd4 = 64'h4444;
        tick();
        idle();
        #1;
        check("post_rst_write", rd1_n, 64'h4444);
        check_all("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
